gray_counter: RTL and testbench

Synchronous up/down binary counter that produces a registered Gray-coded count and its binary equivalent, both updated on the same edge. It is the upstream producer for the Gray decoder stage. Typical uses are as a pointer generator for clock-domain-crossing FIFOs, where only one bit of the Gray output may change per step, and as a stimulus source for decoder checks.

---
 rtl/gray_counter.sv | 117 +++++++++++
 tb/tb_gray_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//
// Up/down binary counter that presents its count both in binary and in
// Gray code. Both outputs are registered from the same next-state value,
// so they always describe the same count. This makes the block usable as a
// pointer source for clock-domain-crossing FIFOs: every enabled step that
// changes the count flips exactly one bit of o_gray.
//
// Parameters
//   DATA_WIDTH : count width in bits (2 or more)
//   WRAP       : 1 = wrap modulo 2^DATA_WIDTH, 0 = saturate at 0 / all-ones
//
// Ports
//   i_clock    : rising-edge clock
//   i_aresetn  : asynchronous active-low reset (released synchronously)
//   i_enable   : advance the count by one step this cycle
//   i_up       : direction, 1 = up, 0 = down (used only for enabled steps)
//   i_load     : synchronous load of i_load_bin, overrides i_enable
//   i_load_bin : binary value to load
//   o_gray     : registered Gray code of the current count
//   o_bin      : registered binary value of the current count
//   o_boundary : one-cycle pulse after a step that wrapped (WRAP=1) or was
//                blocked by saturation (WRAP=0)
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int WRAP       = 1
) (
  input  logic                  i_clock,
  input  logic                  i_aresetn,
  input  logic                  i_enable,
  input  logic                  i_up,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_bin,
  output logic [DATA_WIDTH-1:0] o_gray,
  output logic [DATA_WIDTH-1:0] o_bin,
  output logic                  o_boundary
);

  localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
  localparam bit                    WRAP_EN  = (WRAP != 0);

  logic [DATA_WIDTH-1:0] bin_reg;
  logic [DATA_WIDTH-1:0] gray_reg;
  logic                  boundary_reg;

  logic [DATA_WIDTH-1:0] bin_next;
  logic [DATA_WIDTH-1:0] gray_next;
  logic                  boundary_next;

  logic at_max;
  logic at_zero;

  assign at_max  = (bin_reg == ALL_ONES);
  assign at_zero = (bin_reg == ZERO);

  // Next-state selection: load beats step; a step at a limit either wraps
  // (natural modulo arithmetic) or is held, and in both cases flags the
  // boundary.
  always_comb begin
    bin_next      = bin_reg;
    boundary_next = 1'b0;
    if (i_load) begin
      bin_next = i_load_bin;
    end else if (i_enable) begin
      if (i_up) begin
        if (at_max) begin
          boundary_next = 1'b1;
          if (WRAP_EN) begin
            bin_next = ZERO;
          end
        end else begin
          bin_next = bin_reg + ONE;
        end
      end else begin
        if (at_zero) begin
          boundary_next = 1'b1;
          if (WRAP_EN) begin
            bin_next = ALL_ONES;
          end
        end else begin
          bin_next = bin_reg - ONE;
        end
      end
    end
  end

  // Gray encoding of the next count: each bit is the XOR of a binary bit
  // with its upper neighbour; the MSB passes straight through.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_gray
      assign gray_next[gi] = bin_next[gi] ^ bin_next[gi+1];
    end
  endgenerate
  assign gray_next[DATA_WIDTH-1] = bin_next[DATA_WIDTH-1];

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      bin_reg      <= ZERO;
      gray_reg     <= ZERO;
      boundary_reg <= 1'b0;
    end else begin
      bin_reg      <= bin_next;
      gray_reg     <= gray_next;
      boundary_reg <= boundary_next;
    end
  end

  assign o_bin      = bin_reg;
  assign o_gray     = gray_reg;
  assign o_boundary = boundary_reg;

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//
// Two 4-bit counters, one wrapping and one saturating, share the same
// stimulus. The driver updates an integer reference model per instance and
// pushes the expected outputs into a queue after each clock edge; a monitor
// pops one entry per cycle on the falling edge and compares. The monitor also
// checks the Gray relationships on every cycle.
// -----------------------------------------------------------------------------
module tb_gray_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] lb;
  logic [3:0] gray1, bin1, gray0, bin0;
  logic       bnd1, bnd0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] bin1;
    logic [3:0] gray1;
    logic       bnd1;
    logic       mv1;
    logic [3:0] bin0;
    logic [3:0] gray0;
    logic       bnd0;
    logic       mv0;
  } exp_t;

  exp_t q[$];

  int cnt1 = 0;
  int cnt0 = 0;

  gray_counter #(.DATA_WIDTH(4), .WRAP(1)) dut_wrap (
    .i_clock(clk), .i_aresetn(rst_n), .i_enable(en), .i_up(up),
    .i_load(ld), .i_load_bin(lb),
    .o_gray(gray1), .o_bin(bin1), .o_boundary(bnd1)
  );

  gray_counter #(.DATA_WIDTH(4), .WRAP(0)) dut_sat (
    .i_clock(clk), .i_aresetn(rst_n), .i_enable(en), .i_up(up),
    .i_load(ld), .i_load_bin(lb),
    .o_gray(gray0), .o_bin(bin0), .o_boundary(bnd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [3:0] gray_of(input int v);
    int g;
    g = (v ^ (v / 2)) % 16;
    return g[3:0];
  endfunction

  function automatic int decode(input logic [3:0] g);
    int b;
    int acc;
    b = 0;
    acc = 0;
    for (int i = 3; i >= 0; i--) begin
      acc = acc ^ int'(g[i]);
      b = b * 2 + acc;
    end
    return b;
  endfunction

  // Reference behaviour on a 0..15 integer count.
  function automatic void model_step(input bit l, input bit e, input bit u,
                                     input int lv, input bit wrap,
                                     inout int cnt, output bit bnd, output bit mv);
    int nxt;
    bnd = 1'b0;
    mv  = 1'b0;
    if (l) begin
      cnt = lv;
    end else if (e) begin
      nxt = u ? cnt + 1 : cnt - 1;
      if (nxt < 0 || nxt > 15) begin
        bnd = 1'b1;
        if (wrap) begin
          cnt = (nxt + 16) % 16;
          mv  = 1'b1;
        end
      end else begin
        cnt = nxt;
        mv  = 1'b1;
      end
    end
  endfunction

  task automatic step(input bit l, input bit e, input bit u, input int lv);
    exp_t x;
    bit   b;
    bit   m;
    int   lv_m;
    lv_m = lv % 16;
    ld = l;
    en = e;
    up = u;
    lb = lv_m[3:0];
    model_step(l, e, u, lv_m, 1'b1, cnt1, b, m);
    x.bin1 = cnt1[3:0]; x.gray1 = gray_of(cnt1); x.bnd1 = b; x.mv1 = m;
    model_step(l, e, u, lv_m, 1'b0, cnt0, b, m);
    x.bin0 = cnt0[3:0]; x.gray0 = gray_of(cnt0); x.bnd0 = b; x.mv0 = m;
    @(posedge clk);
    q.push_back(x);
    #1;
  endtask

  // Monitor: one expected entry per clock cycle, compared on the falling edge.
  initial begin
    exp_t       x;
    logic [3:0] p1;
    logic [3:0] p0;
    p1 = 4'd0;
    p0 = 4'd0;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("wrap_bin", int'(bin1), int'(x.bin1));
        chk("wrap_gray", int'(gray1), int'(x.gray1));
        chk("wrap_boundary", int'(bnd1), int'(x.bnd1));
        chk("sat_bin", int'(bin0), int'(x.bin0));
        chk("sat_gray", int'(gray0), int'(x.gray0));
        chk("sat_boundary", int'(bnd0), int'(x.bnd0));
        chk("wrap_gray_formula", int'(gray1), int'(bin1 ^ (bin1 >> 1)));
        chk("sat_gray_formula", int'(gray0), int'(bin0 ^ (bin0 >> 1)));
        chk("wrap_gray_decode", decode(gray1), int'(bin1));
        chk("sat_gray_decode", decode(gray0), int'(bin0));
        if (x.mv1) chk("wrap_gray_onebit", $countones(gray1 ^ p1), 1);
        if (x.mv0) chk("sat_gray_onebit", $countones(gray0 ^ p0), 1);
      end
      p1 = gray1;
      p0 = gray0;
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    up    = 1'b0;
    ld    = 1'b0;
    lb    = 4'd0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_bin", int'(bin1), 0);
    chk("reset_gray", int'(gray1), 0);
    chk("reset_boundary", int'(bnd1), 0);
    chk("reset_sat_bin", int'(bin0), 0);
    rst_n = 1'b1;

    // Up-count through a full wrap
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 0);
      chk("upcount_boundary", int'(bnd1), (i == 15) ? 1 : 0);
    end
    chk("upcount_end_bin", int'(bin1), 0);
    chk("upcount_end_gray", int'(gray1), 0);

    // Down-wrap from 0
    step(1'b0, 1'b1, 1'b0, 0);
    chk("downwrap_bin", int'(bin1), 15);
    chk("downwrap_gray", int'(gray1), 8);
    chk("downwrap_boundary", int'(bnd1), 1);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("downwrap_pulse_end", int'(bnd1), 0);

    // Load versus enable
    step(1'b1, 1'b1, 1'b1, 7);
    chk("load_bin", int'(bin1), 7);
    chk("load_gray", int'(gray1), 4);
    chk("load_boundary", int'(bnd1), 0);
    step(1'b0, 1'b1, 1'b1, 0);
    chk("load_step_bin", int'(bin1), 8);
    chk("load_step_gray", int'(gray1), 12);

    // Saturation on the WRAP=0 instance
    step(1'b1, 1'b0, 1'b0, 14);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 0);
      chk("sat_hi_bin", int'(bin0), 15);
      chk("sat_hi_boundary", int'(bnd0), (i == 0) ? 0 : 1);
    end
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("sat_lo_bin", int'(bin0), 0);
    chk("sat_lo_boundary", int'(bnd0), 1);

    // Asynchronous reset mid-run with count at 9
    step(1'b1, 1'b0, 1'b0, 9);
    step(1'b0, 1'b0, 1'b0, 0);
    chk("pre_reset_bin", int'(bin1), 9);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_bin", int'(bin1), 0);
    chk("async_reset_gray", int'(gray1), 0);
    chk("async_reset_sat_bin", int'(bin0), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cnt1 = 0;
    cnt0 = 0;
    step(1'b0, 1'b1, 1'b1, 0);
    chk("post_reset_bin", int'(bin1), 1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) != 0, int'($urandom_range(0, 15)));
    end
    step(1'b0, 1'b0, 1'b0, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
